// File: rtl/multi_core_boot_sequencer.sv
// Boot and run controller for an array of cores: holds resets, issues start
// pulses (all at once or staggered), then supervises the run until done or timeout.
module multi_core_boot_sequencer #(
    parameter int unsigned NUM_CORES    = 4,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned CNT_BITS     = 16,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned STAGGER      = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    go,
    input  logic                    abort,
    input  logic [NUM_CORES-1:0]    core_mask,
    input  logic [ADDRESS_BITS-1:0] boot_address,
    input  logic [CNT_BITS-1:0]     run_limit,
    input  logic [NUM_CORES-1:0]    core_done,
    output logic [NUM_CORES-1:0]    core_reset,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [ADDRESS_BITS-1:0] prog_address,
    output logic                    report,
    output logic                    busy,
    output logic                    timeout,
    output logic [CNT_BITS-1:0]     cycle_count
);

    localparam int unsigned STEP_MAX = (RESET_CYCLES > NUM_CORES) ? RESET_CYCLES : NUM_CORES;
    localparam int unsigned STEP_W   = (STEP_MAX < 2) ? 1 : $clog2(STEP_MAX);

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_START, S_RUN, S_REPORT} state_t;

    state_t                  r_state,        w_state;
    logic [STEP_W-1:0]       r_step,         w_step;
    logic [NUM_CORES-1:0]    r_mask,         w_mask;
    logic [CNT_BITS-1:0]     r_limit,        w_limit;
    logic [NUM_CORES-1:0]    r_core_reset,   w_core_reset;
    logic [NUM_CORES-1:0]    r_core_start,   w_core_start;
    logic [ADDRESS_BITS-1:0] r_prog_address, w_prog_address;
    logic                    r_report,       w_report;
    logic                    r_busy,         w_busy;
    logic                    r_timeout,      w_timeout;
    logic [CNT_BITS-1:0]     r_cycle_count,  w_cycle_count;
    logic [STEP_W-1:0]       w_step_inc;
    logic [NUM_CORES-1:0]    w_first_sel;
    logic [NUM_CORES-1:0]    w_next_sel;

    assign w_step_inc  = r_step + STEP_W'(1);
    assign w_first_sel = (STAGGER != 0) ? (r_mask & NUM_CORES'(1)) : r_mask;
    assign w_next_sel  = r_mask & (NUM_CORES'(1) << w_step_inc);

    // Outputs are computed for the upcoming state so every port is a register.
    always_comb begin
        w_state        = r_state;
        w_step         = r_step;
        w_mask         = r_mask;
        w_limit        = r_limit;
        w_core_reset   = r_core_reset;
        w_core_start   = '0;
        w_prog_address = r_prog_address;
        w_report       = 1'b0;
        w_timeout      = r_timeout;
        w_cycle_count  = r_cycle_count;

        case (r_state)
            S_IDLE: begin
                w_core_reset = '1;
                if (go && (core_mask != '0)) begin
                    w_state        = S_HOLD;
                    w_step         = '0;
                    w_mask         = core_mask;
                    w_limit        = run_limit;
                    w_prog_address = boot_address;
                    w_timeout      = 1'b0;
                    w_cycle_count  = '0;
                end
            end
            S_HOLD: begin
                if (r_step == STEP_W'(RESET_CYCLES - 1)) begin
                    w_state      = S_START;
                    w_step       = '0;
                    w_core_start = w_first_sel;
                    w_core_reset = r_core_reset & ~w_first_sel;
                end else begin
                    w_step = w_step_inc;
                end
            end
            S_START: begin
                if ((STAGGER == 0) || (r_step == STEP_W'(NUM_CORES - 1))) begin
                    w_state       = S_RUN;
                    w_cycle_count = CNT_BITS'(1);
                end else begin
                    w_step       = w_step_inc;
                    w_core_start = w_next_sel;
                    w_core_reset = r_core_reset & ~w_next_sel;
                end
            end
            S_RUN: begin
                if ((core_done & r_mask) == r_mask) begin
                    w_state   = S_REPORT;
                    w_report  = 1'b1;
                    w_timeout = 1'b0;
                end else if ((r_limit != '0) && (r_cycle_count == r_limit)) begin
                    w_state   = S_REPORT;
                    w_report  = 1'b1;
                    w_timeout = 1'b1;
                end else if (r_cycle_count != '1) begin
                    w_cycle_count = r_cycle_count + CNT_BITS'(1);
                end
            end
            S_REPORT: begin
                w_state      = S_IDLE;
                w_core_reset = '1;
            end
            default: begin
                w_state      = S_IDLE;
                w_core_reset = '1;
            end
        endcase

        // Abort overrides whatever the state logic above decided.
        if (abort && (r_state != S_IDLE)) begin
            w_state       = S_IDLE;
            w_step        = r_step;
            w_core_reset  = '1;
            w_core_start  = '0;
            w_report      = 1'b0;
            w_timeout     = r_timeout;
            w_cycle_count = r_cycle_count;
        end

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_step         <= '0;
            r_mask         <= '0;
            r_limit        <= '0;
            r_core_reset   <= '1;
            r_core_start   <= '0;
            r_prog_address <= '0;
            r_report       <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout      <= 1'b0;
            r_cycle_count  <= '0;
        end else begin
            r_state        <= w_state;
            r_step         <= w_step;
            r_mask         <= w_mask;
            r_limit        <= w_limit;
            r_core_reset   <= w_core_reset;
            r_core_start   <= w_core_start;
            r_prog_address <= w_prog_address;
            r_report       <= w_report;
            r_busy         <= w_busy;
            r_timeout      <= w_timeout;
            r_cycle_count  <= w_cycle_count;
        end
    end

    assign core_reset   = r_core_reset;
    assign core_start   = r_core_start;
    assign prog_address = r_prog_address;
    assign report       = r_report;
    assign busy         = r_busy;
    assign timeout      = r_timeout;
    assign cycle_count  = r_cycle_count;

endmodule

// File: doc/multi_core_boot_sequencer.md
# multi_core_boot_sequencer

Synthesizable boot and run controller for up to NUM_CORES RISC-V cores. It drives each core's reset, start, and program address, then supervises the run. It reports completion, or a cycle-limit timeout, through a one-cycle report pulse. It sits between the SoC control logic and the core array, and replaces hand-sequenced reset/start stimulus with a reusable hardware sequence.

## Interface
Parameters:
- NUM_CORES, 4, number of core channels (1..32)
- ADDRESS_BITS, 20, program address width
- CNT_BITS, 16, width of the run-cycle counter and limit
- RESET_CYCLES, 2, cycles core_reset is held in HOLD (≥1)
- STAGGER, 0, 0 = start all masked cores in one cycle; 1 = start one core per cycle

Ports:
- clock  input  1  sole clock; all state changes on its rising edge
- reset  input  1  synchronous, active-low sequencer reset
- go  input  1  request a boot; sampled only in IDLE
- abort  input  1  cancel the sequence; acted on in any non-IDLE state
- core_mask  input  NUM_CORES  cores taking part; latched on accepted go
- boot_address  input  ADDRESS_BITS  program start address; latched on accepted go
- run_limit  input  CNT_BITS  timeout in RUN cycles; 0 = no limit; latched on accepted go
- core_done  input  NUM_CORES  per-core completion level
- core_reset  output  NUM_CORES  active-high reset to each core
- core_start  output  NUM_CORES  one-cycle start pulse per core
- prog_address  output  ADDRESS_BITS  latched boot address
- report  output  1  one-cycle end-of-run pulse
- busy  output  1  high in every state except IDLE
- timeout  output  1  last run ended because the limit was reached
- cycle_count  output  CNT_BITS  RUN cycles counted in the current or last run

## Operation
- All outputs are registered.
- Reset values: core_reset all ones, core_start 0, prog_address 0, report 0, busy 0, timeout 0, cycle_count 0, state IDLE.
- IDLE: core_reset all ones.
  - go=1 with core_mask≠0: latch mask, address and limit; clear timeout and cycle_count; go to HOLD.
  - go with core_mask=0: ignored.
- HOLD: core_reset all ones for exactly RESET_CYCLES cycles; prog_address shows the latched address; then START.
- START:
  - STAGGER=0: lasts 1 cycle. Every masked core i gets core_start[i]=1 and core_reset[i]=0 in this cycle.
  - STAGGER=1: lasts NUM_CORES cycles. In START cycle j, core j (if masked) gets its start pulse and its reset released in that same cycle.
  - Unmasked cores keep core_reset=1 throughout.
  - Released cores stay released until IDLE.
- RUN:
  - cycle_count increments by 1 each RUN cycle; the first RUN cycle shows 1. It saturates at all ones.
  - Exit 1: (core_done & mask) == mask → REPORT with timeout=0.
  - Exit 2: limit≠0 and cycle_count == limit → REPORT with timeout=1.
  - If both occur in the same cycle, done wins and timeout=0.
- REPORT: report=1 for one cycle; next state IDLE. cycle_count and timeout hold until the next accepted go.
- abort=1 in HOLD, START, RUN or REPORT: the next state is IDLE.
  - core_reset returns to all ones and core_start to 0 on that edge.
  - No report pulse; timeout unchanged.
  - abort has priority over every other transition.
- go while busy: ignored. abort in IDLE: ignored.
- reset asserted mid-sequence: all registers return to reset values on the next edge.
- core_done of unmasked cores is ignored.

## Timing
- go sampled high at edge k (IDLE) → busy=1 and HOLD from k+1.
- START at edge k+1+RESET_CYCLES.
- First RUN cycle at k+2+RESET_CYCLES (STAGGER=0) or k+1+RESET_CYCLES+NUM_CORES (STAGGER=1).
- Completion detected in a RUN cycle → report=1 on the next edge → busy=0 the edge after.
- Timeout with limit L: report asserts the cycle after cycle_count shows L.
- abort sampled at edge m → IDLE values visible from m+1.

## Test plan
- Basic boot: NUM_CORES=4, RESET_CYCLES=2, STAGGER=0, mask=4'b1111, address=20'h0, limit=0, done asserted 10 RUN cycles after start → core_start=4'b1111 for exactly one cycle; report one cycle; timeout=0; cycle_count=10.
- Partial mask with timeout: mask=4'b0101, address=20'h0400, limit=5, done never asserted → cores 1 and 3 stay in reset; prog_address=20'h0400; report with timeout=1 and cycle_count=5.
- Staggered start: STAGGER=1, mask=4'b1011 → core_start pulses on cores 0, 1, 3 in START cycles 0, 1, 3; none on core 2; RUN begins 4 cycles after START.
- Simultaneous done and limit: limit=7 with all masked done rising in the cycle count=7 → timeout=0, single report pulse.
- Abort mid-RUN: abort at count=3 → core_reset all ones and busy=0 next cycle, no report; a go issued while busy earlier in the run had no effect.
- Reset mid-HOLD plus zero-mask go: reset low during HOLD → every output at its reset value next edge; a following go with mask=0 leaves busy=0.
